core_obi_wb_arbiter: RTL and testbench
======================================

# core_obi_wb_arbiter

Parametrised bridge between the core's req/gnt/rvalid memory ports and the single Wishbone master port of the Controller. It generalises a fixed one-to-one wiring to `NUM_PORTS` core ports, such as instruction and data, sharing one Wishbone bus. Ports are served by round-robin arbitration, byte enables are carried through, and a bus timeout returns an error response. It sits between the core and `Controller` in the processorci top level.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of core-side ports; range 1..8.
- `ADDR_WIDTH`, 32: address width, per port and on Wishbone.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `TIMEOUT_CYCLES`, 1024: maximum Wishbone wait in cycles before an error response; 0 disables the timeout.

Ports (per-port buses are flattened; port k occupies slice k):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in NUM_PORTS: request from port k.
- `gnt_o` out NUM_PORTS: request of port k accepted this cycle.
- `we_i` in NUM_PORTS: 1 = write.
- `be_i` in NUM_PORTS*DATA_WIDTH/8: byte enables.
- `addr_i` in NUM_PORTS*ADDR_WIDTH: byte address.
- `wdata_i` in NUM_PORTS*DATA_WIDTH: write data.
- `rvalid_o` out NUM_PORTS: one-cycle response pulse.
- `rdata_o` out NUM_PORTS*DATA_WIDTH: read data, valid with `rvalid_o[k]`.
- `err_o` out NUM_PORTS: response is an error, valid with `rvalid_o[k]`.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone control.
- `wb_sel_o` out DATA_WIDTH/8: Wishbone byte select.
- `wb_adr_o` out ADDR_WIDTH: Wishbone address.
- `wb_dat_o` out DATA_WIDTH: Wishbone write data.
- `wb_dat_i` in DATA_WIDTH: Wishbone read data.
- `wb_ack_i`, `wb_err_i` in 1 each: Wishbone termination.

## Operation

- The block has one outstanding transaction in total. The FSM is IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - Winner is the first k with `req_i[k]`=1, searching from `rr_ptr` upward with wrap-around.
  - `gnt_o[winner]`=1 combinationally in the same cycle.
  - `we`, `be`, `addr`, `wdata` and the winner index are latched at the clock edge; next state is BUS.
  - No request: all outputs stay idle.
- BUS:
  - `wb_cyc_o`=`wb_stb_o`=1, driven from registers.
  - `wb_sel_o`=latched `be`; `wb_we_o`/`wb_adr_o`/`wb_dat_o` come from the latched values.
  - The timeout counter increments each cycle.
  - Exit to RESP on `wb_ack_i`, `wb_err_i`, or counter = `TIMEOUT_CYCLES`-1 when the timeout is enabled.
  - On exit, `wb_dat_i` is captured for reads; the capture is 0 on error or timeout, and 0 for writes.
- Simultaneous termination:
  - `wb_err_i` with `wb_ack_i`: error wins.
  - `wb_ack_i` in the timeout cycle: ack wins, no error.
- RESP:
  - `rvalid_o[winner]`=1 for exactly one cycle.
  - `err_o[winner]` = err OR timeout.
  - `rdata_o` slice = captured data.
  - `rr_ptr` ← winner+1 mod NUM_PORTS; next state is IDLE.
- `rdata_o` slices hold their last value between responses. `err_o` is 0 whenever `rvalid_o` is 0.
- `gnt_o` is never asserted outside IDLE, so a port that keeps `req_i` high waits.
- Ports must keep `req_i` and the payload stable until granted. The block does not check this.
- `NUM_PORTS`=1 degenerates to a pass-through with fixed grant; `rr_ptr` stays 0.

## Timing

- Reset (`rst`=1 at a rising edge):
  - Next cycle: state IDLE, `rr_ptr`=0, counter 0.
  - `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0; `wb_sel_o`, `wb_adr_o`, `wb_dat_o`=0.
  - `rvalid_o`, `err_o`, `rdata_o`=0.
  - `gnt_o`=0 while `rst`=1.
- Reset mid-transaction: Wishbone is abandoned (`cyc` drops the next cycle) and no `rvalid_o` is issued.
- Latency, with req at cycle 0 in IDLE:
  - `gnt_o` at cycle 0.
  - `wb_cyc_o` at cycles 1..n, where `wb_ack_i` arrives at cycle n.
  - `rvalid_o` at cycle n+1.
  - Next grant no earlier than cycle n+2.
  - Zero-wait slave (ack at cycle 1): response at cycle 2, throughput one transfer per 3 cycles.
- Timeout (enabled, no ack): `cyc` is high for exactly `TIMEOUT_CYCLES` cycles, then the error response follows in the next cycle.

## Test plan

- Reset values: `rst` high for 3 cycles with `req_i`=2'b11 → `gnt_o`=0, `wb_cyc_o`=0, all outputs 0.
- Single read:
  - Stimulus: port 0 reads 0x0000_0010, be=4'hF; slave acks 2 cycles after `cyc` with 0xDEAD_BEEF.
  - Required: `gnt_o[0]` at cycle 0, `cyc` at cycles 1–2, `rvalid_o[0]`=1 at cycle 3, `rdata_o[31:0]`=0xDEAD_BEEF, `err_o`=0.
- Round-robin:
  - Stimulus: both ports request continuously; zero-wait slave.
  - Required: grants alternate 0,1,0,1; each port gets a response every 6 cycles; `rvalid_o[1]` never coincides with `rvalid_o[0]`.
- Byte-lane write:
  - Stimulus: port 1 writes 0x1122_3344 to 0x8000_0004 with be=4'b0110.
  - Required: `wb_sel_o`=4'b0110, `wb_we_o`=1, `wb_dat_o`=0x1122_3344; response has `err_o[1]`=0.
- Error and timeout:
  - Stimulus A: `TIMEOUT_CYCLES`=8, slave never acks. Required: `cyc` high for 8 cycles, then `rvalid_o`=1 with `err_o`=1 and `rdata_o`=0.
  - Stimulus B: `wb_ack_i` and `wb_err_i` asserted together. Required: `err_o`=1.
- Reset mid-transaction: assert `rst` during BUS → `wb_cyc_o`=0 the next cycle, no `rvalid_o`; the first request after reset is granted to port 0.

Source files
------------

// File: rtl/core_obi_wb_arbiter.sv
// Round-robin bridge from NUM_PORTS core req/gnt/rvalid ports onto a single
// Wishbone master port. Only one transaction is in flight at a time.
// A bus that never terminates is cut off after TIMEOUT_CYCLES and reported
// to the port as an error response.
module core_obi_wb_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_PORTS-1:0]               req_i,
  output logic [NUM_PORTS-1:0]               gnt_o,
  input  logic [NUM_PORTS-1:0]               we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]               rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]    rdata_o,
  output logic [NUM_PORTS-1:0]               err_o,
  output logic                               wb_cyc_o,
  output logic                               wb_stb_o,
  output logic                               wb_we_o,
  output logic [DATA_WIDTH/8-1:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0]              wb_adr_o,
  output logic [DATA_WIDTH-1:0]              wb_dat_o,
  input  logic [DATA_WIDTH-1:0]              wb_dat_i,
  input  logic                               wb_ack_i,
  input  logic                               wb_err_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t                 state_reg;
  logic [PW-1:0]          rr_ptr_reg;
  logic [PW-1:0]          winner_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   cyc_reg;
  logic                   we_reg;
  logic [BW-1:0]          sel_reg;
  logic [ADDR_WIDTH-1:0]  adr_reg;
  logic [DATA_WIDTH-1:0]  dat_reg;
  logic [NUM_PORTS-1:0]   rvalid_reg;
  logic [NUM_PORTS-1:0]   err_reg;
  logic [DATA_WIDTH-1:0]  rdata_reg [NUM_PORTS];

  logic                   pick_valid;
  logic [PW-1:0]          pick_idx;
  int                     cand;
  logic                   timeout_hit;
  logic                   bus_done;

  // Timeout fires on the last allowed wait cycle; a zero setting disables it.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);
  assign bus_done    = wb_ack_i || wb_err_i || timeout_hit;

  // Round-robin search: first requesting port at or above rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (int'(rr_ptr_reg) + i) % NUM_PORTS;
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  // Grant is combinational, only in IDLE and never while reset is held.
  always_comb begin
    gnt_o = '0;
    if (!rst && state_reg == ST_IDLE && pick_valid) begin
      gnt_o[pick_idx] = 1'b1;
    end
  end

  // Transaction FSM: latch the winner's request, run the bus, pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      winner_reg <= '0;
      cnt_reg    <= '0;
      cyc_reg    <= 1'b0;
      we_reg     <= 1'b0;
      sel_reg    <= '0;
      adr_reg    <= '0;
      dat_reg    <= '0;
      rvalid_reg <= '0;
      err_reg    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rdata_reg[i] <= '0;
      end
    end else begin
      rvalid_reg <= '0;
      err_reg    <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            winner_reg <= pick_idx;
            we_reg     <= we_i[pick_idx];
            sel_reg    <= be_i[pick_idx*BW +: BW];
            adr_reg    <= addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            dat_reg    <= wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            cnt_reg    <= '0;
            cyc_reg    <= 1'b1;
            state_reg  <= ST_BUS;
          end
        end
        ST_BUS: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus_done) begin
            cyc_reg                <= 1'b0;
            state_reg              <= ST_RESP;
            rvalid_reg[winner_reg] <= 1'b1;
            // err beats ack; ack beats a timeout in the same cycle
            err_reg[winner_reg]    <= wb_err_i || !wb_ack_i;
            rdata_reg[winner_reg]  <= (wb_ack_i && !wb_err_i && !we_reg) ? wb_dat_i : '0;
          end
        end
        ST_RESP: begin
          rr_ptr_reg <= (int'(winner_reg) == NUM_PORTS - 1) ? '0 : winner_reg + 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wb_cyc_o = cyc_reg;
  assign wb_stb_o = cyc_reg;
  assign wb_we_o  = we_reg;
  assign wb_sel_o = sel_reg;
  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;
  assign rvalid_o = rvalid_reg;
  assign err_o    = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rdata
      assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_core_obi_wb_arbiter.sv
// Bench for core_obi_wb_arbiter: directed transactions followed by random
// traffic, predicted by a transaction-level timeline model.
module tb_core_obi_wb_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;
  localparam int NC = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    req = '0, we = '0, gnt, rvalid, err;
  logic [NP*BW-1:0] be = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*DW-1:0] wdata = '0, rdata;
  logic wb_cyc, wb_stb, wb_we, wb_ack = 1'b0, wb_err = 1'b0;
  logic [BW-1:0] wb_sel;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i = '0;

  always #5 clk = ~clk;

  core_obi_wb_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err));

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Expected timeline, indexed by cycle of the main phase.
  logic [NP-1:0] e_gnt [NC];
  logic [NP-1:0] e_rv  [NC];
  logic [NP-1:0] e_er  [NC];
  bit            e_cyc [NC];
  bit            e_we  [NC];
  logic [BW-1:0] e_sel [NC];
  logic [AW-1:0] e_adr [NC];
  logic [DW-1:0] e_wd  [NC];
  bit            s_ack [NC];
  bit            s_err [NC];
  logic [DW-1:0] s_dat [NC];
  int            e_rport [NC];
  logic [DW-1:0] e_rval  [NC];

  // Port-side request state and model bookkeeping.
  bit            pend   [NP];
  bit            p_we   [NP];
  logic [BW-1:0] p_be   [NP];
  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_wd   [NP];
  logic [DW-1:0] m_rdata [NP];
  int rr, next_free, w, kind, d, lat, r, dir_req, dir_gnt;
  logic [DW-1:0] rd;

  // Directed transactions: kind 0 ack, 1 err, 2 ack+err, 3 never terminates.
  int            d_port [5] = '{0, 1, 0, 1, 0};
  bit            d_we   [5] = '{0, 1, 0, 0, 0};
  logic [BW-1:0] d_be   [5] = '{4'hF, 4'b0110, 4'hF, 4'hF, 4'hF};
  logic [AW-1:0] d_addr [5] = '{32'h0000_0010, 32'h8000_0004, 32'h20, 32'h30, 32'h40};
  logic [DW-1:0] d_wd   [5] = '{32'h0, 32'h1122_3344, 32'h0, 32'h0, 32'h0};
  int            d_kind [5] = '{0, 0, 3, 2, 0};
  int            d_dly  [5] = '{2, 1, 8, 3, 8};
  logic [DW-1:0] d_rdat [5] = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h55AA_55AA, 32'hCAFE_F00D};

  initial begin
    for (int t = 0; t < NC; t++) begin
      e_gnt[t] = '0; e_rv[t] = '0; e_er[t] = '0; e_cyc[t] = 0; e_we[t] = 0;
      e_sel[t] = '0; e_adr[t] = '0; e_wd[t] = '0; s_ack[t] = 0; s_err[t] = 0;
      s_dat[t] = '0; e_rport[t] = -1; e_rval[t] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      pend[p] = 0; p_we[p] = 0; p_be[p] = '0; p_addr[p] = '0; p_wd[p] = '0; m_rdata[p] = '0;
    end
    rr = 0; next_free = 0; dir_req = 0; dir_gnt = 0;

    // Reset with both ports requesting: nothing may be granted or driven.
    rst = 1'b1; req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk); #1;
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_cyc", {wb_cyc, wb_stb, wb_we}, 0);
      check_eq("rst_bus", {wb_sel, wb_adr, wb_dat_o}, 0);
      check_eq("rst_resp", {rvalid, err}, 0);
      check_eq("rst_rdata", rdata, 0);
    end
    rst = 1'b0; req = '0;

    for (int c = 0; c < NC; c++) begin
      cyc_n = c;
      // New requests: directed ones one at a time, then random traffic.
      if (c + 12 < NC) begin
        if (dir_req < 5) begin
          if (!pend[0] && !pend[1] && c >= next_free) begin
            w = d_port[dir_req];
            pend[w] = 1; p_we[w] = d_we[dir_req]; p_be[w] = d_be[dir_req];
            p_addr[w] = d_addr[dir_req]; p_wd[w] = d_wd[dir_req];
            dir_req++;
          end
        end else begin
          for (int p = 0; p < NP; p++) begin
            if (!pend[p] && $urandom_range(0, 9) < 7) begin
              pend[p] = 1; p_we[p] = 1'($urandom_range(0, 1)); p_be[p] = BW'($urandom);
              p_addr[p] = $urandom; p_wd[p] = $urandom;
            end
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        req[p] = (c + 12 < NC) ? pend[p] : 1'b0;
        we[p] = p_we[p];
        be[p*BW +: BW] = p_be[p];
        addr[p*AW +: AW] = p_addr[p];
        wdata[p*DW +: DW] = p_wd[p];
      end

      // Model: round-robin winner among pending ports once the bus is free.
      w = -1;
      if (c >= next_free && c + 12 < NC) begin
        for (int i = 0; i < NP; i++) begin
          if (w < 0 && pend[(rr + i) % NP]) w = (rr + i) % NP;
        end
      end
      if (w >= 0) begin
        e_gnt[c] = NP'(1) << w;
        if (dir_gnt < 5) begin
          kind = d_kind[dir_gnt]; d = d_dly[dir_gnt]; rd = d_rdat[dir_gnt]; dir_gnt++;
        end else begin
          r = $urandom_range(0, 9);
          kind = (r < 7) ? 0 : r - 6;
          d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO) : $urandom_range(1, 2);
          rd = $urandom;
        end
        lat = (kind == 3) ? TO : d;
        for (int t = c + 1; t <= c + lat; t++) begin
          e_cyc[t] = 1; e_we[t] = p_we[w]; e_sel[t] = p_be[w];
          e_adr[t] = p_addr[w]; e_wd[t] = p_wd[w];
        end
        if (kind != 3) begin
          s_ack[c + d] = (kind == 0 || kind == 2);
          s_err[c + d] = (kind == 1 || kind == 2);
          s_dat[c + d] = rd;
        end
        e_rv[c + lat + 1] = NP'(1) << w;
        e_er[c + lat + 1] = (kind != 0) ? NP'(1) << w : '0;
        e_rport[c + lat + 1] = w;
        e_rval[c + lat + 1] = (kind == 0 && !p_we[w]) ? rd : '0;
        next_free = c + lat + 2;
        rr = (w + 1) % NP;
        pend[w] = 0;
      end

      // Slave side: terminate as planned, random data otherwise.
      wb_ack = s_ack[c];
      wb_err = s_err[c];
      wb_dat_i = (s_ack[c] || s_err[c]) ? s_dat[c] : $urandom;
      if (e_rport[c] >= 0) m_rdata[e_rport[c]] = e_rval[c];

      #1;
      check_eq("gnt", gnt, e_gnt[c]);
      check_eq("cyc", wb_cyc, e_cyc[c]);
      check_eq("stb", wb_stb, e_cyc[c]);
      check_eq("rvalid", rvalid, e_rv[c]);
      check_eq("err", err, e_er[c]);
      check_eq("rdata", rdata, {m_rdata[1], m_rdata[0]});
      if (e_cyc[c]) begin
        check_eq("wb_we", wb_we, e_we[c]);
        check_eq("wb_sel", wb_sel, e_sel[c]);
        check_eq("wb_adr", wb_adr, e_adr[c]);
        check_eq("wb_dat", wb_dat_o, e_wd[c]);
      end
      if (w >= 0 || e_rv[c] != 0)
        $display("cycle %0d grant %b rvalid %b err %b rdata %h", c, gnt, rvalid, err, rdata);
      @(negedge clk);
    end

    // Reset in the middle of a bus cycle; port 1 is the only requester.
    cyc_n = NC;
    wb_ack = 0; wb_err = 0;
    req = 2'b10; we = 2'b00; addr = {32'h0000_0100, 32'h0000_0200};
    #1; check_eq("mid_gnt", gnt, 2'b10);
    @(negedge clk); req = '0; #1;
    check_eq("mid_cyc", wb_cyc, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_eq("mid_drop", wb_cyc, 0);
    check_eq("mid_norv", rvalid, 0);
    rst = 1'b0; req = 2'b11; #1;
    check_eq("post_gnt", gnt, 2'b01);
    @(negedge clk); req = '0; wb_ack = 1; wb_dat_i = 32'h0BAD_F00D; #1;
    check_eq("post_cyc", wb_cyc, 1);
    check_eq("post_adr", wb_adr, 32'h0000_0200);
    check_eq("post_norv", rvalid, 0);
    @(negedge clk); wb_ack = 0; #1;
    check_eq("post_rv", rvalid, 2'b01);
    check_eq("post_rd", rdata[31:0], 32'h0BAD_F00D);
    $display("reset mid-transaction sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
